// File: rtl/parking_slot_router.sv
// Parking slot allocator: grants a free slot per entry request (auto lowest-free
// or manual index), releases slots on exit, and tracks occupancy with registered outputs.
module parking_slot_router #(
  parameter int N_SLOTS = 4,
  parameter int SLOT_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic [SLOT_W-1:0]   switch,
  input  logic                entry_req,
  input  logic                exit_req,
  input  logic [SLOT_W-1:0]   exit_slot,
  output logic                grant_valid,
  output logic [SLOT_W-1:0]   grant_slot,
  output logic [N_SLOTS-1:0]  slot_pulse,
  output logic                reject,
  output logic                exit_err,
  output logic [N_SLOTS-1:0]  occupied,
  output logic [SLOT_W:0]     count,
  output logic                full
);

  logic                auto_found;
  logic [SLOT_W-1:0]   auto_idx;
  logic                manual_ok;
  logic                exit_ok;
  logic                accept;
  logic [SLOT_W-1:0]   alloc_idx;
  logic [N_SLOTS-1:0]  occ_next;
  logic [N_SLOTS-1:0]  hot_next;
  logic [SLOT_W:0]     count_next;
  logic                full_next;

  // Both requests are judged against the pre-edge map, so a slot vacated this
  // cycle cannot be handed out until the following cycle.
  always_comb begin
    auto_found = 1'b0;
    auto_idx   = '0;
    manual_ok  = 1'b0;
    exit_ok    = 1'b0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!occupied[i]) begin
        auto_found = 1'b1;
        auto_idx   = SLOT_W'(i);
      end
    end
    for (int i = 0; i < N_SLOTS; i++) begin
      if (int'(switch) == i && !occupied[i]) manual_ok = 1'b1;
      if (int'(exit_slot) == i && occupied[i]) exit_ok = 1'b1;
    end
  end

  always_comb begin
    accept     = entry_req && !full && (mode ? manual_ok : auto_found);
    alloc_idx  = mode ? switch : auto_idx;
    occ_next   = occupied;
    hot_next   = '0;
    count_next = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (exit_req && exit_ok && int'(exit_slot) == i) occ_next[i] = 1'b0;
      if (accept && int'(alloc_idx) == i) begin
        occ_next[i] = 1'b1;
        hot_next[i] = 1'b1;
      end
    end
    for (int i = 0; i < N_SLOTS; i++) begin
      count_next = count_next + (SLOT_W+1)'(occ_next[i]);
    end
    full_next = (count_next == (SLOT_W+1)'(N_SLOTS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupied    <= '0;
      count       <= '0;
      full        <= 1'b0;
      grant_valid <= 1'b0;
      grant_slot  <= '0;
      slot_pulse  <= '0;
      reject      <= 1'b0;
      exit_err    <= 1'b0;
    end else begin
      occupied    <= occ_next;
      count       <= count_next;
      full        <= full_next;
      grant_valid <= accept;
      slot_pulse  <= hot_next;
      reject      <= entry_req && !accept;
      exit_err    <= exit_req && !exit_ok;
      if (accept) grant_slot <= alloc_idx;
    end
  end

endmodule

// File: tb/tb_parking_slot_router.sv
// Directed bench for parking_slot_router: a 4-slot instance for the main
// scenarios and a 5-slot instance for out-of-range index handling.
module tb_parking_slot_router;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       mode4 = 1'b0, entry4 = 1'b0, exit4 = 1'b0;
  logic [1:0] switch4 = '0, exit_slot4 = '0;
  logic       gv4, rej4, xerr4, full4;
  logic [1:0] gslot4;
  logic [3:0] pulse4, occ4;
  logic [2:0] cnt4;

  logic       mode5 = 1'b0, entry5 = 1'b0, exit5 = 1'b0;
  logic [2:0] switch5 = '0, exit_slot5 = '0;
  logic       gv5, rej5, xerr5, full5;
  logic [2:0] gslot5;
  logic [4:0] pulse5, occ5;
  logic [3:0] cnt5;

  int n_cmp = 0;
  int n_err = 0;

  parking_slot_router #(.N_SLOTS(4), .SLOT_W(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode4), .switch(switch4),
    .entry_req(entry4), .exit_req(exit4), .exit_slot(exit_slot4),
    .grant_valid(gv4), .grant_slot(gslot4), .slot_pulse(pulse4),
    .reject(rej4), .exit_err(xerr4), .occupied(occ4), .count(cnt4), .full(full4)
  );

  parking_slot_router #(.N_SLOTS(5), .SLOT_W(3)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode5), .switch(switch5),
    .entry_req(entry5), .exit_req(exit5), .exit_slot(exit_slot5),
    .grant_valid(gv5), .grant_slot(gslot5), .slot_pulse(pulse5),
    .reject(rej5), .exit_err(xerr5), .occupied(occ5), .count(cnt5), .full(full5)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input logic gv, input logic rej, input logic xe,
                        input logic [3:0] occ, input logic [2:0] cnt, input logic fl);
    check_val({tag, ".grant_valid"}, 32'(gv4), 32'(gv));
    check_val({tag, ".reject"}, 32'(rej4), 32'(rej));
    check_val({tag, ".exit_err"}, 32'(xerr4), 32'(xe));
    check_val({tag, ".occupied"}, 32'(occ4), 32'(occ));
    check_val({tag, ".count"}, 32'(cnt4), 32'(cnt));
    check_val({tag, ".full"}, 32'(full4), 32'(fl));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #1;
    check4("rst", 0, 0, 0, 4'b0000, 3'd0, 0);
    check_val("rst.grant_slot", 32'(gslot4), 0);
    check_val("rst.slot_pulse", 32'(pulse4), 0);
    #20 rst_n = 1'b1;

    // auto fill 0..3
    for (int k = 0; k < 4; k++) begin
      mode4 = 1'b0; entry4 = 1'b1;
      step();
      check4($sformatf("auto%0d", k), 1, 0, 0, 4'((1 << (k + 1)) - 1), 3'(k + 1), k == 3);
      check_val($sformatf("auto%0d.grant_slot", k), 32'(gslot4), 32'(k));
      check_val($sformatf("auto%0d.slot_pulse", k), 32'(pulse4), 32'(1 << k));
    end
    // fifth entry while full
    step();
    check4("auto_full", 0, 1, 0, 4'b1111, 3'd4, 1);
    check_val("auto_full.grant_slot", 32'(gslot4), 3);
    check_val("auto_full.slot_pulse", 32'(pulse4), 0);

    // full: entry with exit of slot 2 in same cycle
    entry4 = 1'b1; exit4 = 1'b1; exit_slot4 = 2'd2;
    step();
    check4("same_cyc", 0, 1, 0, 4'b1011, 3'd3, 0);
    exit4 = 1'b0;
    step();
    check4("after_free", 1, 0, 0, 4'b1111, 3'd4, 1);
    check_val("after_free.grant_slot", 32'(gslot4), 2);

    // free slot 3, then exit it again -> error
    entry4 = 1'b0; exit4 = 1'b1; exit_slot4 = 2'd3;
    step();
    check4("exit3", 0, 0, 0, 4'b0111, 3'd3, 0);
    step();
    check4("exit3_again", 0, 0, 1, 4'b0111, 3'd3, 0);

    // build 0101 then manual allocation
    exit_slot4 = 2'd1;
    step();
    check4("exit1", 0, 0, 0, 4'b0101, 3'd2, 0);
    exit4 = 1'b0; entry4 = 1'b1; mode4 = 1'b1; switch4 = 2'd1;
    step();
    check4("man1", 1, 0, 0, 4'b0111, 3'd3, 0);
    check_val("man1.grant_slot", 32'(gslot4), 1);
    check_val("man1.slot_pulse", 32'(pulse4), 32'b0010);
    switch4 = 2'd2;
    step();
    check4("man2_taken", 0, 1, 0, 4'b0111, 3'd3, 0);
    check_val("man2_taken.grant_slot", 32'(gslot4), 1);
    switch4 = 2'd3;
    step();
    check4("man3", 1, 0, 0, 4'b1111, 3'd4, 1);
    check_val("man3.slot_pulse", 32'(pulse4), 32'b1000);
    entry4 = 1'b0; mode4 = 1'b0;
    step();
    check4("idle", 0, 0, 0, 4'b1111, 3'd4, 1);
    check_val("idle.grant_slot", 32'(gslot4), 3);
    check_val("idle.slot_pulse", 32'(pulse4), 0);

    // five-slot instance: out-of-range manual index and exit slot
    mode5 = 1'b1; entry5 = 1'b1; switch5 = 3'd6;
    step();
    check_val("n5_sw6.reject", 32'(rej5), 1);
    check_val("n5_sw6.grant_valid", 32'(gv5), 0);
    check_val("n5_sw6.count", 32'(cnt5), 0);
    switch5 = 3'd4;
    step();
    check_val("n5_sw4.grant_valid", 32'(gv5), 1);
    check_val("n5_sw4.grant_slot", 32'(gslot5), 4);
    check_val("n5_sw4.slot_pulse", 32'(pulse5), 32'b10000);
    check_val("n5_sw4.count", 32'(cnt5), 1);
    entry5 = 1'b0; exit5 = 1'b1; exit_slot5 = 3'd7;
    step();
    check_val("n5_ex7.exit_err", 32'(xerr5), 1);
    check_val("n5_ex7.occupied", 32'(occ5), 32'b10000);
    exit_slot5 = 3'd4;
    step();
    check_val("n5_ex4.exit_err", 32'(xerr5), 0);
    check_val("n5_ex4.occupied", 32'(occ5), 0);
    check_val("n5_ex4.count", 32'(cnt5), 0);
    exit5 = 1'b0; mode5 = 1'b0;

    // mid-cycle reset while a grant is showing and another request is pending
    exit4 = 1'b1; exit_slot4 = 2'd0;
    step();
    check4("pre_rst_exit", 0, 0, 0, 4'b1110, 3'd3, 0);
    exit4 = 1'b0; entry4 = 1'b1;
    step();
    check4("pre_rst_grant", 1, 0, 0, 4'b1111, 3'd4, 1);
    #2 rst_n = 1'b0;
    #1;
    check4("async_rst", 0, 0, 0, 4'b0000, 3'd0, 0);
    check_val("async_rst.grant_slot", 32'(gslot4), 0);
    check_val("async_rst.slot_pulse", 32'(pulse4), 0);
    step();
    check4("in_rst", 0, 0, 0, 4'b0000, 3'd0, 0);
    entry4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check4("post_rst_idle", 0, 0, 0, 4'b0000, 3'd0, 0);
    entry4 = 1'b1;
    step();
    check4("post_rst_entry", 1, 0, 0, 4'b0001, 3'd1, 0);
    check_val("post_rst_entry.grant_slot", 32'(gslot4), 0);
    entry4 = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
